shift64_assembler: RTL and testbench

- Serial-to-parallel counterpart of the team's 64-bit load/shift register: accepts a stream of bytes or single bits and shifts them in MSB-first to assemble 64-bit words.
- Uses a valid/ready handshake on both sides.
- A flush command emits a partial word, right-aligned and optionally sign-extended; this is the inverse of the arithmetic right shift on the load side.
- Sits between a byte/bit link receiver and any consumer of 64-bit words.

---
 rtl/shift64_pkg.sv | 13 +
 rtl/sext_mask.sv | 26 ++
 rtl/shift64_assembler.sv | 99 +++++++++
 tb/tb_shift64_assembler.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/shift64_pkg.sv
// rtl/shift64_pkg.sv - shared types and constants for the 64-bit word assembler
package shift64_pkg;

    typedef enum logic {
        FILL = 1'b0,
        OUT  = 1'b1
    } asm_state_t;

    localparam int   BYTE_BITS = 8;
    localparam logic MODE_BYTE = 1'b0;
    localparam logic MODE_BIT  = 1'b1;

endpackage

// File: rtl/sext_mask.sv
// rtl/sext_mask.sv - fill mask and fill bit for extending a right-aligned partial word
module sext_mask #(
    parameter int W  = 64,
    parameter int CW = 7
) (
    input  logic [CW-1:0] cnt,
    input  logic          sext,
    input  logic [W-1:0]  data,
    output logic [W-1:0]  mask,
    output logic          fill
);

    localparam int IW = $clog2(W);

    logic [IW-1:0] top_idx;

    // mask covers bits [W-1:cnt]; a full word (cnt == W) yields an empty mask
    always_comb begin
        top_idx = cnt[IW-1:0] - 1'b1;
        fill    = sext && (cnt != '0) && data[top_idx];
        for (int i = 0; i < W; i++) begin
            mask[i] = (CW'(i) >= cnt);
        end
    end

endmodule

// File: rtl/shift64_assembler.sv
// rtl/shift64_assembler.sv - MSB-first byte/bit stream to 64-bit word assembler with flush
module shift64_assembler
    import shift64_pkg::*;
#(
    parameter int W  = 64,
    parameter int CW = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          mode,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [7:0]    in_data,
    input  logic          flush,
    input  logic          sext,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic [CW-1:0] out_bits
);

    asm_state_t    state, state_nxt;
    logic [W-1:0]  q, q_nxt, fill_mask, word;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          mode_l, eff_mode, beat, fill_bit, go_out;

    // the mode input only matters on the first beat of a word
    always_comb begin
        eff_mode = (cnt == '0) ? mode : mode_l;
        beat     = (state == FILL) && in_valid;
        q_nxt    = q;
        cnt_nxt  = cnt;
        if (beat) begin
            if (eff_mode == MODE_BIT) begin
                q_nxt   = {q[W-2:0], in_data[0]};
                cnt_nxt = cnt + CW'(1);
            end else begin
                q_nxt   = {q[W-BYTE_BITS-1:0], in_data};
                cnt_nxt = cnt + CW'(BYTE_BITS);
            end
        end
        go_out = (cnt_nxt == CW'(W)) || (flush && (cnt_nxt != '0));
    end

    sext_mask #(
        .W  (W),
        .CW (CW)
    ) u_sext_mask (
        .cnt  (cnt_nxt),
        .sext (sext),
        .data (q_nxt),
        .mask (fill_mask),
        .fill (fill_bit)
    );

    assign word = q_nxt | (fill_bit ? fill_mask : '0);

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            FILL: begin
                in_ready = 1'b1;
                if (go_out) state_nxt = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = FILL;
            end
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FILL;
        else        state <= state_nxt;
    end

    // q doubles as the output holding register while in OUT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q      <= '0;
            cnt    <= '0;
            mode_l <= MODE_BYTE;
        end else if (state == FILL) begin
            if (beat) mode_l <= eff_mode;
            cnt <= cnt_nxt;
            q   <= go_out ? word : q_nxt;
        end else if (out_ready) begin
            q   <= '0;
            cnt <= '0;
        end
    end

    assign out_data = (state == OUT) ? q : '0;
    assign out_bits = (state == OUT) ? cnt : '0;

endmodule

// File: tb/tb_shift64_assembler.sv
// tb/tb_shift64_assembler.sv - directed vector bench for shift64_assembler
module tb_shift64_assembler;

    localparam int W  = 64;
    localparam int CW = 7;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          mode;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_data;
    logic          flush;
    logic          sext;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [CW-1:0] out_bits;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    shift64_assembler #(.W(W), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .flush     (flush),
        .sext      (sext),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_bits  (out_bits)
    );

    // fmode: 0 = no flush, 1 = flush with the last beat, 2 = flush on its own cycle after
    typedef struct {
        logic        m;
        int          n;
        logic [63:0] payload;
        int          fmode;
        logic        sx;
        logic [63:0] exp_data;
        int          exp_bits;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic m, input logic [7:0] d, input logic fl, input logic sx);
        mode     = m;
        in_data  = d;
        flush    = fl;
        sext     = sx;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic flush_only(input logic sx);
        flush = 1'b1;
        sext  = sx;
        tick();
        flush = 1'b0;
    endtask

    task automatic send_bytes(input logic [63:0] p, input int n);
        for (int k = 0; k < n; k++) begin
            beat(1'b0, p[8*(n-1-k) +: 8], 1'b0, 1'b0);
        end
    endtask

    task automatic take_word();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        vec_t        r;
        logic [7:0]  d;
        logic [63:0] held;

        vecs[0] = '{1'b0, 8,  64'h0102030405060708, 0, 1'b0, 64'h0102030405060708, 64};
        vecs[1] = '{1'b1, 64, 64'hAAAAAAAAAAAAAAAA, 0, 1'b0, 64'hAAAAAAAAAAAAAAAA, 64};
        vecs[2] = '{1'b0, 2,  64'h0000000000008001, 2, 1'b1, 64'hFFFFFFFFFFFF8001, 16};
        vecs[3] = '{1'b0, 2,  64'h0000000000008001, 2, 1'b0, 64'h0000000000008001, 16};
        vecs[4] = '{1'b0, 8,  64'hDEADBEEFCAFEF00D, 1, 1'b1, 64'hDEADBEEFCAFEF00D, 64};
        vecs[5] = '{1'b1, 3,  64'h0000000000000005, 2, 1'b1, 64'hFFFFFFFFFFFFFFFD, 3};
        vecs[6] = '{1'b1, 5,  64'h000000000000000D, 1, 1'b1, 64'h000000000000000D, 5};
        vecs[7] = '{1'b0, 3,  64'h0000000000FF0011, 1, 1'b0, 64'h0000000000FF0011, 24};

        rst_n     = 1'b0;
        mode      = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        flush     = 1'b0;
        sext      = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_bits", 64'(out_bits), 64'd0);
        rst_n = 1'b1;
        tick();

        // flush with nothing received is dropped
        flush_only(1'b1);
        chk("empty_flush_valid", 64'(out_valid), 64'd0);
        chk("empty_flush_ready", 64'(in_ready), 64'd1);

        for (int v = 0; v < 8; v++) begin
            r = vecs[v];
            for (int k = 0; k < r.n; k++) begin
                if (r.m) d = {7'b0, r.payload[r.n-1-k]};
                else     d = r.payload[8*(r.n-1-k) +: 8];
                chk($sformatf("v%0d_ready_b%0d", v, k), 64'(in_ready), 64'd1);
                // mode flips after the first beat must not affect the word
                beat((k == 0) ? r.m : ~r.m, d, (r.fmode == 1) && (k == r.n - 1), r.sx);
                if (k != r.n - 1) chk($sformatf("v%0d_early_valid_b%0d", v, k), 64'(out_valid), 64'd0);
            end
            if (r.fmode == 2) begin
                chk($sformatf("v%0d_prefl_valid", v), 64'(out_valid), 64'd0);
                flush_only(r.sx);
            end
            chk($sformatf("v%0d_valid", v), 64'(out_valid), 64'd1);
            chk($sformatf("v%0d_in_ready", v), 64'(in_ready), 64'd0);
            chk($sformatf("v%0d_data", v), out_data, r.exp_data);
            chk($sformatf("v%0d_bits", v), 64'(out_bits), 64'(r.exp_bits));
            take_word();
            chk($sformatf("v%0d_post_valid", v), 64'(out_valid), 64'd0);
            chk($sformatf("v%0d_post_ready", v), 64'(in_ready), 64'd1);
            chk($sformatf("v%0d_post_bits", v), 64'(out_bits), 64'd0);
        end

        // backpressure: word held for 5 cycles while inputs are poked
        send_bytes(64'hA1A2A3A4A5A6A7A8, 8);
        held = 64'hA1A2A3A4A5A6A7A8;
        for (int c = 0; c < 5; c++) begin
            in_valid = c[0];
            in_data  = 8'hFF;
            flush    = (c == 2);
            sext     = 1'b1;
            tick();
            chk($sformatf("bp_valid_c%0d", c), 64'(out_valid), 64'd1);
            chk($sformatf("bp_in_ready_c%0d", c), 64'(in_ready), 64'd0);
            chk($sformatf("bp_data_c%0d", c), out_data, held);
            chk($sformatf("bp_bits_c%0d", c), 64'(out_bits), 64'd64);
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        take_word();
        chk("bp_release_valid", 64'(out_valid), 64'd0);
        send_bytes(64'h0F1E2D3C4B5A6978, 8);
        chk("bp_next_data", out_data, 64'h0F1E2D3C4B5A6978);
        chk("bp_next_bits", 64'(out_bits), 64'd64);
        take_word();

        // asynchronous reset mid-word discards the partial word
        send_bytes(64'h00000000EEEEEEEE, 4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_out_data", out_data, 64'd0);
        chk("arst_out_bits", 64'(out_bits), 64'd0);
        #1;
        rst_n = 1'b1;
        tick();
        send_bytes(64'h1122334455667788, 8);
        chk("arst_clean_valid", 64'(out_valid), 64'd1);
        chk("arst_clean_data", out_data, 64'h1122334455667788);
        chk("arst_clean_bits", 64'(out_bits), 64'd64);
        take_word();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
